input_debouncer: RTL and testbench

- Sits directly upstream of the input mapping stage; first block on the raw controller button path.
- Synchronises the 12 raw controller buttons into the core clock domain and debounces each one with a stable-count filter.
- Drives clean, registered button levels and one-cycle press strobes.
- The mapping stage consumes the levels and multiplexes them onto the MPU K/BA/beta/ACL inputs.

---
 rtl/input_debouncer_if.sv | 30 +++
 rtl/input_debouncer.sv | 95 +++++++++
 tb/tb_input_debouncer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_debouncer_if                                                   |
// | Raw button / debounced button bundle between pad logic and mapping.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface input_debouncer_if;
  logic        sample_tick;
  logic [11:0] buttons_raw;
  logic [11:0] buttons;
  logic [11:0] pressed;
  logic [11:0] released;

  modport master (
    output sample_tick,
    output buttons_raw,
    input  buttons,
    input  pressed,
    input  released
  );

  modport slave (
    input  sample_tick,
    input  buttons_raw,
    output buttons,
    output pressed,
    output released
  );
endinterface
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | input_debouncer                                                      |
// | Synchronises and stable-count debounces 12 controller buttons.       |
// | Optional macro INPUT_SOCD_CLEAN_EN: d-pad opposing-direction cleaning|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module input_debouncer #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input_debouncer_if.slave bus
);

  localparam int                 c_NB       = 12;
  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_NB-1:0]    r_sync [SYNC_STAGES];
  logic [c_CNT_W-1:0] r_cnt  [c_NB];
  logic [c_NB-1:0]    r_filt;
  logic [c_NB-1:0]    r_btn;
  logic [c_NB-1:0]    r_pressed;
  logic [c_NB-1:0]    r_released;

  logic [c_NB-1:0]    w_s;
  logic [c_NB-1:0]    w_filt_next;
  logic [c_NB-1:0]    w_btn_next;
  logic [c_CNT_W-1:0] w_cnt_next [c_NB];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= bus.buttons_raw;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Any tick that agrees with the current level clears the count, so a
  // bounce has to persist for DEBOUNCE_TICKS consecutive ticks to pass.
  always_comb begin
    w_filt_next = r_filt;
    for (int i = 0; i < c_NB; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (bus.sample_tick) begin
        if (w_s[i] == r_filt[i]) begin
          w_cnt_next[i] = '0;
        end else if (r_cnt[i] == c_CNT_LAST) begin
          w_filt_next[i] = w_s[i];
          w_cnt_next[i]  = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + c_CNT_ONE;
        end
      end
    end
  end

`ifdef INPUT_SOCD_CLEAN_EN
  always_comb begin
    w_btn_next = w_filt_next;
    if (w_filt_next[0] && w_filt_next[1]) w_btn_next[1:0] = 2'b00;
    if (w_filt_next[2] && w_filt_next[3]) w_btn_next[3:2] = 2'b00;
  end
`else
  assign w_btn_next = w_filt_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_NB; i++) r_cnt[i] <= '0;
      r_filt     <= '0;
      r_btn      <= '0;
      r_pressed  <= '0;
      r_released <= '0;
    end else begin
      for (int i = 0; i < c_NB; i++) r_cnt[i] <= w_cnt_next[i];
      r_filt     <= w_filt_next;
      r_btn      <= w_btn_next;
      r_pressed  <= w_btn_next & ~r_btn;
      r_released <= ~w_btn_next & r_btn;
    end
  end

  assign bus.buttons  = r_btn;
  assign bus.pressed  = r_pressed;
  assign bus.released = r_released;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_input_debouncer                                                   |
// | Directed self-checking bench, DEBOUNCE_TICKS=4, SYNC_STAGES=2.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_input_debouncer;

  logic clk = 1'b0;
  logic reset;
  int   n_err = 0;
  int   n_chk = 0;

  input_debouncer_if bus ();

  input_debouncer #(
    .DEBOUNCE_TICKS (4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.buttons_raw = '0;
    bus.sample_tick = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [11:0] eb, ep;
    reset           = 1'b1;
    bus.buttons_raw = 12'hFFF;
    bus.sample_tick = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if (bus.buttons !== 12'h000 || bus.pressed !== 12'h000) begin
        n_err++;
        $display("FAIL reset_hold c=%0d buttons=%h pressed=%h expected 000/000", c, bus.buttons, bus.pressed);
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      eb = (k >= 5) ? 12'hFFF : 12'h000;
      ep = (k == 5) ? 12'hFFF : 12'h000;
      n_chk++;
      if (bus.buttons !== eb || bus.pressed !== ep || bus.released !== 12'h000) begin
        n_err++;
        $display("FAIL reset_release k=%0d buttons=%h pressed=%h released=%h expected %h/%h/000", k, bus.buttons, bus.pressed, bus.released, eb, ep);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] eb, ep;
    do_reset();
    bus.buttons_raw = 12'h010;
    for (int k = 0; k < 8; k++) begin
      step();
      eb = (k >= 5) ? 12'h010 : 12'h000;
      ep = (k == 5) ? 12'h010 : 12'h000;
      n_chk++;
      if (bus.buttons !== eb || bus.pressed !== ep) begin
        n_err++;
        $display("FAIL clean_press k=%0d buttons=%h pressed=%h expected %h/%h", k, bus.buttons, bus.pressed, eb, ep);
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] eb, ep;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      bus.buttons_raw = (k == 3) ? 12'h000 : 12'h001;
      step();
      eb = (k >= 9) ? 12'h001 : 12'h000;
      ep = (k == 9) ? 12'h001 : 12'h000;
      n_chk++;
      if (bus.buttons !== eb || bus.pressed !== ep) begin
        n_err++;
        $display("FAIL bounce k=%0d buttons=%h pressed=%h expected %h/%h", k, bus.buttons, bus.pressed, eb, ep);
      end
    end
  endtask

  task automatic test_tick_gating();
    logic [11:0] eb, ep;
    do_reset();
    bus.buttons_raw = 12'h800;
    for (int k = 0; k < 14; k++) begin
      bus.sample_tick = (k % 3 == 2);
      step();
      eb = (k >= 11) ? 12'h800 : 12'h000;
      ep = (k == 11) ? 12'h800 : 12'h000;
      n_chk++;
      if (bus.buttons !== eb || bus.pressed !== ep) begin
        n_err++;
        $display("FAIL tick_gating k=%0d buttons=%h pressed=%h expected %h/%h", k, bus.buttons, bus.pressed, eb, ep);
      end
    end
    bus.sample_tick = 1'b1;
  endtask

  task automatic test_release();
    logic [11:0] eb, er;
    do_reset();
    bus.buttons_raw = 12'h100;
    repeat (7) step();
    n_chk++;
    if (bus.buttons !== 12'h100) begin
      n_err++;
      $display("FAIL release_setup buttons=%h expected 100", bus.buttons);
    end
    bus.buttons_raw = 12'h000;
    for (int k = 0; k < 7; k++) begin
      step();
      eb = (k >= 5) ? 12'h000 : 12'h100;
      er = (k == 5) ? 12'h100 : 12'h000;
      n_chk++;
      if (bus.buttons !== eb || bus.released !== er || bus.pressed !== 12'h000) begin
        n_err++;
        $display("FAIL release k=%0d buttons=%h released=%h pressed=%h expected %h/%h/000", k, bus.buttons, bus.released, bus.pressed, eb, er);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [11:0] eb;
    do_reset();
    bus.buttons_raw = 12'h020;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      eb = (k >= 5) ? 12'h020 : 12'h000;
      n_chk++;
      if (bus.buttons !== eb) begin
        n_err++;
        $display("FAIL reset_midcount k=%0d buttons=%h expected %h", k, bus.buttons, eb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] eb, ep;
    do_reset();
    bus.buttons_raw = 12'h0A0;
    repeat (2) step();
    bus.buttons_raw = 12'h0A4;
    for (int k = 0; k < 7; k++) begin
      step();
      eb = ((k >= 3) ? 12'h0A0 : 12'h000) | ((k >= 5) ? 12'h004 : 12'h000);
      ep = ((k == 3) ? 12'h0A0 : 12'h000) | ((k == 5) ? 12'h004 : 12'h000);
      n_chk++;
      if (bus.buttons !== eb || bus.pressed !== ep) begin
        n_err++;
        $display("FAIL back_to_back k=%0d buttons=%h pressed=%h expected %h/%h", k, bus.buttons, bus.pressed, eb, ep);
      end
    end
  endtask

  task automatic test_socd();
    logic [11:0] eb, ep, er;
    do_reset();
    bus.buttons_raw = 12'h003;
    for (int k = 0; k < 8; k++) begin
      step();
`ifdef INPUT_SOCD_CLEAN_EN
      eb = 12'h000;
      ep = 12'h000;
`else
      eb = (k >= 5) ? 12'h003 : 12'h000;
      ep = (k == 5) ? 12'h003 : 12'h000;
`endif
      n_chk++;
      if (bus.buttons !== eb || bus.pressed !== ep) begin
        n_err++;
        $display("FAIL socd_both k=%0d buttons=%h pressed=%h expected %h/%h", k, bus.buttons, bus.pressed, eb, ep);
      end
    end
    bus.buttons_raw = 12'h001;
    for (int k = 0; k < 7; k++) begin
      step();
`ifdef INPUT_SOCD_CLEAN_EN
      eb = (k >= 5) ? 12'h001 : 12'h000;
      ep = (k == 5) ? 12'h001 : 12'h000;
      er = 12'h000;
`else
      eb = (k >= 5) ? 12'h001 : 12'h003;
      ep = 12'h000;
      er = (k == 5) ? 12'h002 : 12'h000;
`endif
      n_chk++;
      if (bus.buttons !== eb || bus.pressed !== ep || bus.released !== er) begin
        n_err++;
        $display("FAIL socd_release k=%0d buttons=%h pressed=%h released=%h expected %h/%h/%h", k, bus.buttons, bus.pressed, bus.released, eb, ep, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_tick_gating();
    test_release();
    test_reset_midcount();
    test_back_to_back();
    test_socd();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
